// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [DATA_WIDTH-1:0]    req_a0,
    input  logic [DATA_WIDTH-1:0]    req_b0,
    input  logic [DATA_WIDTH-1:0]    req_a1,
    input  logic [DATA_WIDTH-1:0]    req_b1,
    input  logic [OPCODE_LENGTH-1:0] req_op0,
    input  logic [OPCODE_LENGTH-1:0] req_op1,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_result,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                   state;
    logic [DATA_WIDTH-1:0]    a_q;
    logic [DATA_WIDTH-1:0]    b_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic                     owner;
    logic                     grant;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b10)
            grant = 1'b1;
        else if (req_valid == 2'b11)
            grant = ~last_grant;
    end
`else
    always_comb begin
        grant = (req_valid == 2'b10);
    end
`endif

    // Ready follows valid combinationally so a request can be accepted on the edge it first appears.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && req_valid != 2'b00)
            req_ready = grant ? 2'b10 : 2'b01;
    end

    assign alu_srca = a_q;
    assign alu_srcb = b_q;
    assign alu_op   = op_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            owner      <= 1'b0;
            rsp_valid  <= '0;
            rsp_result <= '0;
`ifdef ALU_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        a_q   <= grant ? req_a1  : req_a0;
                        b_q   <= grant ? req_b1  : req_b0;
                        op_q  <= grant ? req_op1 : req_op0;
                        owner <= grant;
`ifdef ALU_ARB_RR_EN
                        last_grant <= grant;
`endif
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_valid  <= owner ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model on the alu_* side.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OL = 4;

    localparam logic [OL-1:0] OP_AND = 4'b0000;
    localparam logic [OL-1:0] OP_ADD = 4'b0010;
    localparam logic [OL-1:0] OP_SUB = 4'b0110;
    localparam logic [OL-1:0] OP_SRA = 4'b1001;
    localparam logic [OL-1:0] OP_BAD = 4'b1111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [DW-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [OL-1:0] req_op0 = '0, req_op1 = '0;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready = '0;
    logic [DW-1:0] rsp_result;
    logic [DW-1:0] alu_srca, alu_srcb;
    logic [OL-1:0] alu_op;
    logic [DW-1:0] alu_result;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = alu_srca & alu_srcb;
            4'b0001: alu_result = alu_srca | alu_srcb;
            4'b0010: alu_result = alu_srca + alu_srcb;
            4'b0110: alu_result = alu_srca - alu_srcb;
            4'b1001: alu_result = $signed(alu_srca) >>> alu_srcb[4:0];
            default: alu_result = '0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        step();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
        checks++; if (alu_srca !== 32'h0 || alu_srcb !== 32'h0 || alu_op !== 4'h0) begin
            errors++; $display("FAIL reset_alu_bus got=%h/%h/%h exp=0/0/0", alu_srca, alu_srcb, alu_op); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = OP_ADD; req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        step();
        req_valid = '0;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_exec_ready got=%b exp=00", req_ready); end
        checks++; if (alu_srca !== 32'd5 || alu_srcb !== 32'd7 || alu_op !== OP_ADD) begin
            errors++; $display("FAIL single_alu_drive got=%h/%h/%h exp=5/7/2", alu_srca, alu_srcb, alu_op); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_exec_rsp got=%b exp=00", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
        checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL single_rsp_result got=%h exp=c", rsp_result); end
        rsp_ready = 2'b01;
        step();
        rsp_ready = '0;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_clear got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_a0 = 32'h0000_00FF; req_b0 = 32'h0000_0F0F; req_op0 = OP_AND;
        req_a1 = 32'd10;        req_b1 = 32'd3;         req_op1 = OP_SUB;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL simul_first_grant got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b10;
        step();
        checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h0000_000F) begin
            errors++; $display("FAIL simul_rsp0 got=%b/%h exp=01/0000000f", rsp_valid, rsp_result); end
        rsp_ready = 2'b01;
        step();
        rsp_ready = '0;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL simul_second_grant got=%b exp=10", req_ready); end
        step();
        req_valid = '0;
        step();
        checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd7) begin
            errors++; $display("FAIL simul_rsp1 got=%b/%h exp=10/00000007", rsp_valid, rsp_result); end
        rsp_ready = 2'b10;
        step();
        rsp_ready = '0;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL simul_rsp1_clear got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_grant [4];
        logic [DW-1:0] exp_res;
`ifdef ALU_ARB_RR_EN
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = OP_ADD;
        req_a1 = 32'd9; req_b1 = 32'd4; req_op1 = OP_SUB;
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_res = (exp_grant[i] == 2'b01) ? 32'd3 : 32'd5;
            checks++; if (req_ready !== exp_grant[i]) begin
                errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp_grant[i]); end
            step();
            step();
            checks++; if (rsp_valid !== exp_grant[i]) begin
                errors++; $display("FAIL rr_rsp_valid%0d got=%b exp=%b", i, rsp_valid, exp_grant[i]); end
            checks++; if (rsp_result !== exp_res) begin
                errors++; $display("FAIL rr_rsp_result%0d got=%h exp=%h", i, rsp_result, exp_res); end
            rsp_ready = 2'b11;
            step();
            rsp_ready = '0;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        req_a1 = 32'h8000_0000; req_b1 = 32'd4; req_op1 = OP_SRA;
        req_a0 = 32'd100; req_b0 = 32'd1; req_op0 = OP_ADD;
        req_valid = 2'b10;
        #1;
        step();
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'hF800_0000) begin
                errors++; $display("FAIL bp_hold%0d got=%b/%h exp=10/f8000000", i, rsp_valid, rsp_result); end
            checks++; if (req_ready !== 2'b00) begin
                errors++; $display("FAIL bp_ready%0d got=%b exp=00", i, req_ready); end
            step();
        end
        rsp_ready = 2'b10;
        step();
        rsp_ready = '0;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_release got=%b exp=00", rsp_valid); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_idle_ready got=%b exp=01", req_ready); end
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset_mid();
        req_a0 = 32'd20; req_b0 = 32'd22; req_op0 = OP_ADD;
        req_valid = 2'b01;
        step();
        req_valid = '0;
        reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b00 || rsp_result !== 32'h0) begin
            errors++; $display("FAIL midrst_outputs got=%b/%h exp=00/0", rsp_valid, rsp_result); end
        checks++; if (alu_srca !== 32'h0 || alu_op !== 4'h0) begin
            errors++; $display("FAIL midrst_alu got=%h/%h exp=0/0", alu_srca, alu_op); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_no_rsp got=%b exp=00", rsp_valid); end
        req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = OP_ADD;
        req_a1 = 32'd10; req_b1 = 32'd3; req_op1 = OP_SUB;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_grant got=%b exp=01", req_ready); end
        step();
        req_valid = '0;
        step();
        checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd12) begin
            errors++; $display("FAIL midrst_rsp got=%b/%h exp=01/0000000c", rsp_valid, rsp_result); end
        rsp_ready = 2'b01;
        step();
        rsp_ready = '0;
    endtask

    task automatic test_undef_opcode();
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = OP_BAD;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL undef_ready got=%b exp=01", req_ready); end
        step();
        req_valid = '0;
        step();
        checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h0) begin
            errors++; $display("FAIL undef_rsp got=%b/%h exp=01/0", rsp_valid, rsp_result); end
        rsp_ready = 2'b01;
        step();
        rsp_ready = '0;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL undef_clear got=%b exp=00", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_undef_opcode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational `alu` between two requesters (e.g. main pipeline execute stage and an address/branch helper unit). Accepts one operation at a time via valid/ready, registers operands, drives the ALU for one cycle, and registers the result into a response buffer held until the owning requester takes it. Sits between the requesters and the `alu` instance; the ALU itself is unchanged.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width (matches `alu`)
- `OPCODE_LENGTH`, 4, ALU operation code width (matches `alu`)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid[1:0]`  in  2  per-requester operation request
- `req_ready[1:0]`  out  2  per-requester accept; handshake when `req_valid[i] && req_ready[i]`
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  DATA_WIDTH  operands of requester 0/1
- `req_op0`, `req_op1`  in  OPCODE_LENGTH  ALU operation of requester 0/1
- `rsp_valid[1:0]`  out  2  one-hot result-valid toward owning requester
- `rsp_ready[1:0]`  in  2  per-requester result accept
- `rsp_result`  out  DATA_WIDTH  registered ALU result (shared bus)
- `alu_srca`, `alu_srcb`  out  DATA_WIDTH  to ALU `SrcA`/`SrcB`
- `alu_op`  out  OPCODE_LENGTH  to ALU `Operation`
- `alu_result`  in  DATA_WIDTH  from ALU `ALUResult`

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: compute grant from `req_valid` and policy; `req_ready[g]=1` for granted requester only, other 0. On handshake: latch `a`, `b`, `op`, owner=g into registers, update `last_grant=g`, go EXEC. No valid requests -> stay IDLE.
- EXEC: `alu_*` driven from latched registers (always, in every state); capture `alu_result` into `rsp_result`, set `rsp_valid[owner]=1`, go RESP. `req_ready=0`.
- RESP: hold `rsp_result`, `rsp_valid[owner]` stable; `req_ready=0`. On `rsp_ready[owner]` -> clear `rsp_valid`, go IDLE. `rsp_ready` of non-owner ignored.
- Grant policy (round-robin build): one valid -> grant it; both valid -> grant `~last_grant`.
- Opcodes are passed through unchecked; undefined codes return whatever the ALU returns (0).
- `req_ready` may depend combinationally on `req_valid`; requesters must hold operands stable while `req_valid` is high and unaccepted.
- Reset values: state IDLE, `req_ready=0` (until valid seen), `rsp_valid=2'b00`, `rsp_result=0`, operand/op registers 0 (so `alu_srca=alu_srcb=0`, `alu_op=0`), `last_grant=1` (requester 0 wins first tie), owner 0.
- Reset asserted mid-operation: in-flight operation and pending response are discarded immediately; no response is ever produced for it.

## Timing
- Accept at edge E0 -> EXEC during cycle E0..E1 -> `rsp_valid` high after E1 (result latency 1 cycle after accept).
- Earliest response handshake at E2; back in IDLE after E2; next accept earliest at E3. Throughput: one operation per 3 cycles with no backpressure.
- Response backpressure: RESP held indefinitely; `rsp_result` must not change while `rsp_valid` high.
- No combinational path from `alu_result` to any output; `rsp_result` is a register.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin tie-break via `last_grant` as above.
- Not defined: fixed priority, requester 0 always wins ties; `last_grant` unused (may be removed). All other behaviour identical.

## Test plan
- Single op: req0 ADD (`op=4'b0010`) a=5, b=7 -> accepted at E0, `rsp_valid=2'b01`, `rsp_result=12` after E1; `rsp_ready[0]=1` -> IDLE.
- Simultaneous first requests after reset: req0 AND 0x0000_00FF & 0x0000_0F0F, req1 SUB 10-3 -> req0 served first (0x0000_000F), then req1 (7) with `rsp_valid=2'b10`.
- Round-robin (`ALU_ARB_RR_EN`): both requesters hold valid for 4 ops -> grant order 0,1,0,1; fixed-priority build -> 0,0,0,0 and req1 never accepted.
- Backpressure: req1 SRAI a=0x8000_0000, b=4 -> result 0xF800_0000; hold `rsp_ready[1]=0` 5 cycles -> result/valid stable, `req_ready=2'b00` despite req0 valid; `rsp_ready[0]=1` meanwhile has no effect.
- Reset mid-EXEC: assert `reset` during EXEC -> outputs immediately `rsp_valid=0`, `rsp_result=0`; after release, both valid -> requester 0 granted.
- Undefined opcode 4'b1111 a=1, b=1 -> `rsp_result=0`, normal handshake.
